// File: rtl/calendar_counter.sv
// rtl/calendar_counter.sv - day/month calendar counter with validated preset and rollover pulses
module calendar_counter #(
    parameter int LEAP_EN = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       load,
    input  logic [3:0] load_month,
    input  logic [4:0] load_day,
    input  logic       leap,
    output logic [3:0] month,
    output logic [4:0] day,
    output logic       last_day,
    output logic       month_end,
    output logic       year_end,
    output logic       load_err
);

    // Days in month m; out-of-range months never reach state, so they share the 31-day arm.
    function automatic logic [4:0] dim(input logic [3:0] m, input logic lp);
        logic [4:0] d;
        case (m)
            4'd1:                       d = (lp && (LEAP_EN != 0)) ? 5'd29 : 5'd28;
            4'd3, 4'd5, 4'd8, 4'd10:    d = 5'd30;
            default:                    d = 5'd31;
        endcase
        return d;
    endfunction

    logic       load_ok;
    logic [3:0] month_next;

    // Last day uses >= so a Feb 29 left over after leap falls still rolls over on the next tick.
    always_comb begin
        last_day   = (day >= dim(month, leap));
        load_ok    = (load_month <= 4'd11) && (load_day != 5'd0) &&
                     (load_day <= dim(load_month, leap));
        month_next = (month == 4'd11) ? 4'd0 : month + 4'd1;
    end

    // State update: rst over load over tick; a tick alongside a load is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            month     <= 4'd0;
            day       <= 5'd1;
            month_end <= 1'b0;
            year_end  <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            month_end <= 1'b0;
            year_end  <= 1'b0;
            load_err  <= 1'b0;
            if (load) begin
                if (load_ok) begin
                    month <= load_month;
                    day   <= load_day;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (tick) begin
                if (last_day) begin
                    day       <= 5'd1;
                    month     <= month_next;
                    month_end <= 1'b1;
                    year_end  <= (month == 4'd11);
                end else begin
                    day <= day + 5'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_calendar_counter.sv
// tb/tb_calendar_counter.sv - directed self-checking bench for calendar_counter
module tb_calendar_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_month = 4'd0;
    logic [4:0] load_day = 5'd0;
    logic       leap = 1'b0;
    logic [3:0] month;
    logic [4:0] day;
    logic       last_day;
    logic       month_end;
    logic       year_end;
    logic       load_err;

    int pass_cnt = 0;
    int total_cnt = 0;
    int me_cnt;
    int ye_cnt;
    int bad_month;

    calendar_counter #(.LEAP_EN(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .load       (load),
        .load_month (load_month),
        .load_day   (load_day),
        .leap       (leap),
        .month      (month),
        .day        (day),
        .last_day   (last_day),
        .month_end  (month_end),
        .year_end   (year_end),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic do_load(input logic [3:0] m, input logic [4:0] d);
        load = 1'b1;
        load_month = m;
        load_day = d;
        step();
        load = 1'b0;
    endtask

    task automatic check_state(input string tag, input logic [3:0] m, input logic [4:0] d,
                               input logic me, input logic ye, input logic le);
        check({tag, ".month"}, 32'(month), 32'(m));
        check({tag, ".day"}, 32'(day), 32'(d));
        check({tag, ".month_end"}, 32'(month_end), 32'(me));
        check({tag, ".year_end"}, 32'(year_end), 32'(ye));
        check({tag, ".load_err"}, 32'(load_err), 32'(le));
    endtask

    task automatic sweep(input string tag, input int n);
        me_cnt = 0;
        ye_cnt = 0;
        bad_month = 0;
        tick = 1'b1;
        for (int i = 0; i < n; i++) begin
            step();
            if (month_end) me_cnt++;
            if (year_end) ye_cnt++;
            if (month > 4'd11 || day == 5'd0 || day > 5'd31) bad_month++;
        end
        tick = 1'b0;
        check({tag, ".month"}, 32'(month), 32'd0);
        check({tag, ".day"}, 32'(day), 32'd1);
        check({tag, ".month_end_cnt"}, 32'(me_cnt), 32'd12);
        check({tag, ".year_end_cnt"}, 32'(ye_cnt), 32'd1);
        check({tag, ".range_violations"}, 32'(bad_month), 32'd0);
    endtask

    initial begin
        // Reset for two cycles
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check_state("reset", 4'd0, 5'd1, 1'b0, 1'b0, 1'b0);
        check("reset.last_day", 32'(last_day), 32'd0);

        // January: 30 ticks reach Jan 31, no pulses on the way
        me_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            do_tick();
            if (month_end || year_end) me_cnt++;
        end
        check("jan.pulses", 32'(me_cnt), 32'd0);
        check_state("jan31", 4'd0, 5'd31, 1'b0, 1'b0, 1'b0);
        check("jan31.last_day", 32'(last_day), 32'd1);
        do_tick();
        check_state("feb1", 4'd1, 5'd1, 1'b1, 1'b0, 1'b0);
        step();
        check("feb1.pulse_drop", 32'(month_end), 32'd0);

        // Hold with no strobes
        for (int i = 0; i < 5; i++) step();
        check_state("hold", 4'd1, 5'd1, 1'b0, 1'b0, 1'b0);

        // Feb 28, non-leap year
        leap = 1'b0;
        do_load(4'd1, 5'd28);
        check_state("load_feb28", 4'd1, 5'd28, 1'b0, 1'b0, 1'b0);
        check("feb28_nl.last_day", 32'(last_day), 32'd1);
        do_tick();
        check_state("mar1_nl", 4'd2, 5'd1, 1'b1, 1'b0, 1'b0);

        // Feb 28, leap year
        leap = 1'b1;
        do_load(4'd1, 5'd28);
        check("feb28_l.last_day", 32'(last_day), 32'd0);
        do_tick();
        check_state("feb29", 4'd1, 5'd29, 1'b0, 1'b0, 1'b0);
        check("feb29.last_day", 32'(last_day), 32'd1);
        do_tick();
        check_state("mar1_l", 4'd2, 5'd1, 1'b1, 1'b0, 1'b0);

        // Leap falls while sitting on Feb 29
        do_load(4'd1, 5'd29);
        leap = 1'b0;
        #1;
        check("leapfall.last_day", 32'(last_day), 32'd1);
        do_tick();
        check_state("leapfall.mar1", 4'd2, 5'd1, 1'b1, 1'b0, 1'b0);

        // Dec 31 year rollover, pulses last one cycle
        do_load(4'd11, 5'd31);
        do_tick();
        check_state("newyear", 4'd0, 5'd1, 1'b1, 1'b1, 1'b0);
        step();
        check_state("newyear.after", 4'd0, 5'd1, 1'b0, 1'b0, 1'b0);

        // Rejected loads leave Jun 10 intact
        do_load(4'd5, 5'd10);
        check_state("load_jun10", 4'd5, 5'd10, 1'b0, 1'b0, 1'b0);
        do_load(4'd12, 5'd1);
        check_state("rej_m12", 4'd5, 5'd10, 1'b0, 1'b0, 1'b1);
        do_load(4'd3, 5'd31);
        check_state("rej_apr31", 4'd5, 5'd10, 1'b0, 1'b0, 1'b1);
        leap = 1'b0;
        do_load(4'd1, 5'd29);
        check_state("rej_feb29", 4'd5, 5'd10, 1'b0, 1'b0, 1'b1);
        do_load(4'd4, 5'd0);
        check_state("rej_day0", 4'd5, 5'd10, 1'b0, 1'b0, 1'b1);
        step();
        check("rej.pulse_drop", 32'(load_err), 32'd0);

        // Load wins over a coincident tick that would otherwise roll over
        do_load(4'd0, 5'd31);
        tick = 1'b1;
        do_load(4'd5, 5'd10);
        tick = 1'b0;
        check_state("load_tick", 4'd5, 5'd10, 1'b0, 1'b0, 1'b0);

        // Reset wins over coincident tick at Dec 31
        do_load(4'd11, 5'd31);
        rst = 1'b1;
        do_tick();
        rst = 1'b0;
        check_state("rst_tick", 4'd0, 5'd1, 1'b0, 1'b0, 1'b0);

        // Reset wins over coincident load
        rst = 1'b1;
        do_load(4'd5, 5'd10);
        rst = 1'b0;
        check_state("rst_load", 4'd0, 5'd1, 1'b0, 1'b0, 1'b0);

        // Full-year sweeps from Jan 1
        leap = 1'b0;
        sweep("year365", 365);
        leap = 1'b1;
        sweep("year366", 366);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
